emu_stepped_transactor: RTL and testbench

Parametrised successor to the per-design emulation wrappers. It is a generic host-side transactor with byte-addressed stimulus and capture banks of configurable depth. It adds a run-N-cycles sequencer that gates the DUT through a clock enable on the single emulation clock, then auto-captures the DUT outputs and raises a sticky done flag. It sits between the emulator host byte bus and any DUT wrapper.

---
 rtl/emu_pkg.sv | 24 ++
 rtl/emu_cycle_sequencer.sv | 87 ++++++++
 rtl/emu_stepped_transactor.sv | 119 +++++++++++
 tb/tb_emu_stepped_transactor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/emu_pkg.sv
// Shared types and helpers for the stepped emulation transactor.
// Keeps the sequencer state encoding and the host map layout in one place.
package emu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } emu_state_t;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  // The top address of the host window is reserved for STATUS.
  function automatic int status_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  // Low bit index of byte lane 'lane' inside a packed byte vector.
  function automatic int lane_lo(input int lane);
    return 8 * lane;
  endfunction

endpackage

// File: rtl/emu_cycle_sequencer.sv
// Run-N-cycles sequencer: arbitrates host strobes while idle, gates the DUT
// through dut_ce for exactly N edges, then requests one capture cycle.
module emu_cycle_sequencer
  import emu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             load_req,
  input  logic             get_req,
  input  logic             wr_req,
  input  logic [CNT_W-1:0] cycles,
  output logic             run_acc,
  output logic             load_acc,
  output logic             get_acc,
  output logic             wr_acc,
  output logic             capture_en,
  output logic             busy,
  output logic             done,
  output logic             dut_ce
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  emu_state_t       state;
  emu_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic             idle;

  assign idle = (state == IDLE);

  // busy and dut_ce are registered from the next state so they line up
  // with the state they describe rather than trailing it by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dut_ce <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != IDLE);
      dut_ce <= (state_next == RUN);
      if (run_acc) begin
        count <= cycles;
      end else if (state == RUN) begin
        count <= count - CNT_ONE;
      end
      if (run_acc) begin
        done <= 1'b0;
      end else if (capture_en) begin
        done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (run_req) begin
          state_next = (cycles == '0) ? CAPTURE : RUN;
        end
      end
      RUN: begin
        if (count == CNT_ONE) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fixed priority run > load > get > wr; losers in the same cycle are dropped.
  always_comb begin
    run_acc    = idle && run_req;
    load_acc   = idle && !run_req && load_req;
    get_acc    = idle && !run_req && !load_req && get_req;
    wr_acc     = idle && !run_req && !load_req && !get_req && wr_req;
    capture_en = (state == CAPTURE);
  end

endmodule

// File: rtl/emu_stepped_transactor.sv
// Host-side emulation transactor: byte-addressed stimulus and capture banks,
// a registered read port with STATUS, and a run-N-cycles DUT sequencer.
module emu_stepped_transactor
  import emu_pkg::*;
#(
  parameter int STIM_BYTES = 2,
  parameter int OUT_BYTES  = 2,
  parameter int ADDR_W     = 3,
  parameter int CNT_W      = 8,
  parameter int AUTO_LOAD  = 1
) (
  input  logic                    clk_emu,
  input  logic                    rst_emu,
  input  logic [7:0]              Din_emu,
  input  logic [ADDR_W-1:0]       Addr_emu,
  input  logic                    wr_emu,
  input  logic                    load_emu,
  input  logic                    get_emu,
  input  logic                    run_emu,
  input  logic [CNT_W-1:0]        cycles_emu,
  output logic [7:0]              Dout_emu,
  output logic                    busy_emu,
  output logic                    done_emu,
  output logic [8*STIM_BYTES-1:0] stim_vec,
  output logic                    dut_ce,
  input  logic [8*OUT_BYTES-1:0]  out_vec
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(ADDR_W));

  if (STIM_BYTES < 1 || STIM_BYTES >= (1 << ADDR_W) ||
      OUT_BYTES < 1 || OUT_BYTES >= (1 << ADDR_W)) begin : g_bad_map
    $error("emu_stepped_transactor: bank sizes must be 1..2^ADDR_W-1");
  end

  logic                    run_acc;
  logic                    load_acc;
  logic                    get_acc;
  logic                    wr_acc;
  logic                    capture_en;
  logic [8*STIM_BYTES-1:0] stim_bank;
  logic [8*OUT_BYTES-1:0]  cap_bank;
  logic [7:0]              rd_data;
  logic                    stim_load;

  emu_cycle_sequencer #(
    .CNT_W(CNT_W)
  ) u_seq (
    .clk       (clk_emu),
    .rst       (rst_emu),
    .run_req   (run_emu),
    .load_req  (load_emu),
    .get_req   (get_emu),
    .wr_req    (wr_emu),
    .cycles    (cycles_emu),
    .run_acc   (run_acc),
    .load_acc  (load_acc),
    .get_acc   (get_acc),
    .wr_acc    (wr_acc),
    .capture_en(capture_en),
    .busy      (busy_emu),
    .done      (done_emu),
    .dut_ce    (dut_ce)
  );

  assign stim_load = load_acc || ((AUTO_LOAD != 0) && run_acc);

  // Addresses at or beyond STIM_BYTES simply match no lane.
  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      stim_bank <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < STIM_BYTES; i++) begin
        if (Addr_emu == ADDR_W'(i)) begin
          stim_bank[lane_lo(i) +: 8] <= Din_emu;
        end
      end
    end
  end

  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      stim_vec <= '0;
    end else if (stim_load) begin
      stim_vec <= stim_bank;
    end
  end

  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      cap_bank <= '0;
    end else if (get_acc || capture_en) begin
      cap_bank <= out_vec;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (Addr_emu == ADDR_W'(i)) begin
        rd_data = cap_bank[lane_lo(i) +: 8];
      end
    end
    if (Addr_emu == STATUS_ADDR) begin
      rd_data              = '0;
      rd_data[STATUS_BUSY] = busy_emu;
      rd_data[STATUS_DONE] = done_emu;
    end
  end

  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      Dout_emu <= '0;
    end else begin
      Dout_emu <= rd_data;
    end
  end

endmodule

// File: tb/tb_emu_stepped_transactor.sv
// Self-checking bench for emu_stepped_transactor: directed scenarios followed
// by random host traffic, all checked against a transaction-level model.
module tb_emu_stepped_transactor;

  logic        clk_emu = 1'b0;
  logic        rst_emu = 1'b1;
  logic [7:0]  Din_emu = '0;
  logic [2:0]  Addr_emu = '0;
  logic        wr_emu = 1'b0, load_emu = 1'b0, get_emu = 1'b0, run_emu = 1'b0;
  logic [7:0]  cycles_emu = '0;
  logic [7:0]  Dout_emu;
  logic        busy_emu, done_emu, dut_ce;
  logic [15:0] stim_vec;
  logic [15:0] out_vec;

  logic [15:0] dut_cnt;
  logic [15:0] out_drv = '0;
  logic        cnt_clr = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  emu_stepped_transactor dut (
    .clk_emu   (clk_emu),
    .rst_emu   (rst_emu),
    .Din_emu   (Din_emu),
    .Addr_emu  (Addr_emu),
    .wr_emu    (wr_emu),
    .load_emu  (load_emu),
    .get_emu   (get_emu),
    .run_emu   (run_emu),
    .cycles_emu(cycles_emu),
    .Dout_emu  (Dout_emu),
    .busy_emu  (busy_emu),
    .done_emu  (done_emu),
    .stim_vec  (stim_vec),
    .dut_ce    (dut_ce),
    .out_vec   (out_vec)
  );

  always #5 clk_emu = ~clk_emu;

  // Stand-in DUT: counts its enabled clock edges.
  always_ff @(posedge clk_emu) begin
    if (cnt_clr) dut_cnt <= '0;
    else if (dut_ce) dut_cnt <= dut_cnt + 16'd1;
  end
  assign out_vec = dut_cnt ^ out_drv;

  // Transaction-level model: a run is "active" for N+1 cycles after its
  // accepting edge; the DUT is enabled for the first N; capture at the end.
  logic [7:0]  m_bank [2];
  logic [7:0]  m_cap  [2];
  logic [15:0] m_vec;
  logic [7:0]  m_dout;
  bit          m_active, m_done;
  int          m_t, m_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_bank[0] = '0; m_bank[1] = '0; m_cap[0] = '0; m_cap[1] = '0;
    m_vec = '0; m_dout = '0; m_active = 0; m_done = 0; m_t = 0; m_n = 0;
  endfunction

  function automatic void model_step(input bit run, input bit load, input bit get,
                                     input bit wr, input logic [2:0] a,
                                     input logic [7:0] d, input logic [7:0] n,
                                     input logic [15:0] ov);
    logic [7:0] nd;
    if (a < 2)       nd = m_cap[a];
    else if (a == 7) nd = {6'b0, m_done, m_active};
    else             nd = 8'h00;
    if (m_active) begin
      m_t++;
      if (m_t == m_n + 1) begin
        m_cap[0] = ov[7:0]; m_cap[1] = ov[15:8];
        m_done = 1; m_active = 0;
      end
    end else if (run) begin
      m_n = int'(n); m_t = 0; m_active = 1; m_done = 0;
      m_vec = {m_bank[1], m_bank[0]};
    end else if (load) begin
      m_vec = {m_bank[1], m_bank[0]};
    end else if (get) begin
      m_cap[0] = ov[7:0]; m_cap[1] = ov[15:8];
    end else if (wr && a < 2) begin
      m_bank[a] = d;
    end
    m_dout = nd;
  endfunction

  task automatic cycle(input bit run, input bit load, input bit get, input bit wr,
                       input logic [2:0] a, input logic [7:0] d, input logic [7:0] n);
    run_emu = run; load_emu = load; get_emu = get; wr_emu = wr;
    Addr_emu = a; Din_emu = d; cycles_emu = n;
    model_step(run, load, get, wr, a, d, n, dut_cnt ^ out_drv);
    @(posedge clk_emu);
    @(negedge clk_emu);
    chk("dut_ce", dut_ce, m_active && (m_t < m_n));
    chk("busy", busy_emu, m_active);
    chk("done", done_emu, m_done);
    chk("dout", Dout_emu, m_dout);
    chk("stim_vec", stim_vec, m_vec);
  endtask

  task automatic idle(input logic [2:0] a);
    cycle(0, 0, 0, 0, a, 8'h00, 8'h00);
  endtask

  int ce_n, busy_n;

  initial begin
    model_reset();
    repeat (3) @(posedge clk_emu);
    @(negedge clk_emu);
    rst_emu = 1'b0;
    cnt_clr = 1'b0;
    chk("rst_dut_ce", dut_ce, 1'b0);
    chk("rst_stim_vec", stim_vec, 16'h0000);

    idle(3'd0); chk("rst_rd0", Dout_emu, 8'h00);
    idle(3'd1); chk("rst_rd1", Dout_emu, 8'h00);
    idle(3'd7); chk("rst_status", Dout_emu, 8'h00);

    cycle(0, 0, 0, 1, 3'd0, 8'h85, 8'h00);
    cycle(0, 0, 0, 1, 3'd1, 8'h01, 8'h00);
    cycle(0, 1, 0, 0, 3'd0, 8'h00, 8'h00);
    chk("load_vec", stim_vec, 16'h0185);
    out_drv = 16'hBEEF;
    cycle(0, 0, 1, 0, 3'd0, 8'h00, 8'h00);
    idle(3'd0); chk("get_rd0", Dout_emu, 8'hEF);
    idle(3'd1); chk("get_rd1", Dout_emu, 8'hBE);

    // N = 3 against the counting DUT
    out_drv = 16'h0000;
    ce_n = 0; busy_n = 0;
    cycle(1, 0, 0, 0, 3'd7, 8'h00, 8'd3);
    ce_n += int'(dut_ce); busy_n += int'(busy_emu);
    repeat (5) begin
      idle(3'd7);
      ce_n += int'(dut_ce); busy_n += int'(busy_emu);
    end
    chk("n3_ce_cycles", ce_n, 3);
    chk("n3_busy_cycles", busy_n, 4);
    chk("n3_status", Dout_emu, 8'h02);
    idle(3'd0); chk("n3_capture", Dout_emu, 8'h03);

    // N = 0: capture only
    out_drv = 16'h1234;
    ce_n = 0; busy_n = 0;
    cycle(1, 0, 0, 0, 3'd0, 8'h00, 8'd0);
    ce_n += int'(dut_ce); busy_n += int'(busy_emu);
    idle(3'd0);
    ce_n += int'(dut_ce); busy_n += int'(busy_emu);
    chk("n0_ce_cycles", ce_n, 0);
    chk("n0_busy_cycles", busy_n, 1);
    chk("n0_done", done_emu, 1'b1);
    idle(3'd0); chk("n0_capture", Dout_emu, 8'h37);

    // collisions
    cycle(1, 0, 0, 1, 3'd0, 8'hAA, 8'd4);
    chk("coll_run_won", busy_emu, 1'b1);
    cycle(0, 0, 0, 1, 3'd0, 8'h55, 8'h00);
    idle(3'd7); chk("status_in_run", Dout_emu, 8'h01);
    repeat (5) idle(3'd0);
    cycle(0, 1, 0, 0, 3'd0, 8'h00, 8'h00);
    chk("coll_bank_kept", stim_vec, 16'h0185);

    // reset in cycle 2 of a 10-cycle run
    cycle(1, 0, 0, 0, 3'd0, 8'h00, 8'd10);
    idle(3'd0);
    rst_emu = 1'b1;
    #1;
    chk("mid_rst_ce", dut_ce, 1'b0);
    chk("mid_rst_busy", busy_emu, 1'b0);
    chk("mid_rst_done", done_emu, 1'b0);
    model_reset();
    @(negedge clk_emu);
    rst_emu = 1'b0;
    idle(3'd0); chk("mid_rst_cap0", Dout_emu, 8'h00);
    idle(3'd1); chk("mid_rst_cap1", Dout_emu, 8'h00);
    idle(3'd7); chk("mid_rst_status", Dout_emu, 8'h00);
    cycle(1, 0, 0, 0, 3'd7, 8'h00, 8'd2);
    repeat (4) idle(3'd7);
    chk("post_rst_done", done_emu, 1'b1);

    // longest run
    cycle(1, 0, 0, 0, 3'd7, 8'h00, 8'd255);
    repeat (258) idle(3'd7);
    chk("n255_done", done_emu, 1'b1);

    // random host traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] n;
      out_drv = 16'($urandom);
      n = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 8'($urandom), n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
